pipeline_stage_elastic: RTL and testbench

Parametrised elastic pipeline stage. It is the valid/ready successor to the basic flush/stall pipeline register: a 2-entry skid buffer that sustains one beat per cycle with no combinational path from `out_ready` to `in_ready`. Flush and reset place a programmable value on the data bus. It sits between core pipeline stages, and between the core and memory/peripheral ports, wherever backpressure must be cut for timing.

---
 rtl/pipeline_stage_elastic_if.sv | 12 +
 rtl/pipeline_stage_elastic.sv | 108 ++++++++++
 tb/tb_pipeline_stage_elastic.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_elastic_if.sv
// Valid/ready/data handshake bundle used on both sides of pipeline_stage_elastic.
// The master drives valid and data, the slave drives ready.
interface pipeline_stage_elastic_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, input ready, output data);
    modport slave  (input valid, output ready, input data);
endinterface

// File: rtl/pipeline_stage_elastic.sv
// Two-entry elastic (skid-buffer) pipeline stage: one beat per cycle, registered in_ready,
// synchronous flush and asynchronous reset both load RESET_VALUE into the data registers.
module pipeline_stage_elastic #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    pipeline_stage_elastic_if.slave  upstream,
    pipeline_stage_elastic_if.master downstream,
    output logic [1:0]               occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  flush_pending_s;

    // Reserved hook for a deferred flush; tied off so it never blocks acceptance.
    assign flush_pending_s = 1'b0;

    assign in_fire_s  = upstream.valid & in_ready_r;
    assign out_fire_s = out_valid_r & downstream.ready;

    assign upstream.ready   = in_ready_r;
    assign downstream.valid = out_valid_r;
    assign downstream.data  = main_r;
    assign occupancy        = state_r;

    // Next-state decode; in_ready is registered from this so out_ready never reaches it combinationally.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) next_state_s = ONE;
                    else           next_state_s = EMPTY;
                end
                ONE: begin
                    if (in_fire_s && !out_fire_s)      next_state_s = TWO;
                    else if (!in_fire_s && out_fire_s) next_state_s = EMPTY;
                    else                               next_state_s = ONE;
                end
                TWO: begin
                    if (out_fire_s) next_state_s = ONE;
                    else            next_state_s = TWO;
                end
                default: next_state_s = EMPTY;
            endcase
        end
    end

    // State, payload registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= EMPTY;
            main_r      <= RESET_VALUE;
            skid_r      <= RESET_VALUE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (flush) begin
                main_r <= RESET_VALUE;
                skid_r <= RESET_VALUE;
            end else begin
                case (state_r)
                    EMPTY: begin
                        if (in_fire_s) main_r <= upstream.data;
                    end
                    ONE: begin
                        if (in_fire_s && out_fire_s) main_r <= upstream.data;
                        else if (in_fire_s)          skid_r <= upstream.data;
                        else if (out_fire_s)         main_r <= RESET_VALUE;
                    end
                    TWO: begin
                        // Skid beat is older than anything upstream still holds, so it moves up first.
                        if (out_fire_s) begin
                            main_r <= skid_r;
                            skid_r <= RESET_VALUE;
                        end
                    end
                    default: begin
                        main_r <= RESET_VALUE;
                        skid_r <= RESET_VALUE;
                    end
                endcase
            end
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != TWO) && !flush_pending_s;
            out_valid_r <= (next_state_s != EMPTY);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: directed scenarios on a 32-bit instance and a randomised
// queue-model scoreboard run on 8-bit and 64-bit instances sharing one handshake stream.
module tb_pipeline_stage_elastic;

    localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
    localparam logic [7:0]  RV8  = 8'h5A;
    localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    logic reset_n;
    logic flush32;
    logic flush_r;
    logic [1:0] occ32, occ8, occ64;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_stage_elastic_if #(.DATA_WIDTH(32)) i32u ();
    pipeline_stage_elastic_if #(.DATA_WIDTH(32)) i32d ();
    pipeline_stage_elastic_if #(.DATA_WIDTH(8))  i8u ();
    pipeline_stage_elastic_if #(.DATA_WIDTH(8))  i8d ();
    pipeline_stage_elastic_if #(.DATA_WIDTH(64)) i64u ();
    pipeline_stage_elastic_if #(.DATA_WIDTH(64)) i64d ();

    pipeline_stage_elastic #(.DATA_WIDTH(32), .RESET_VALUE(RV32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush32),
        .upstream(i32u), .downstream(i32d), .occupancy(occ32));
    pipeline_stage_elastic #(.DATA_WIDTH(8), .RESET_VALUE(RV8)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush_r),
        .upstream(i8u), .downstream(i8d), .occupancy(occ8));
    pipeline_stage_elastic #(.DATA_WIDTH(64), .RESET_VALUE(RV64)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush_r),
        .upstream(i64u), .downstream(i64d), .occupancy(occ64));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        flush32 = 1'b0; flush_r = 1'b0;
        i32u.valid = 1'b0; i32u.data = '0; i32d.ready = 1'b0;
        i8u.valid = 1'b0; i8u.data = '0; i8d.ready = 1'b0;
        i64u.valid = 1'b0; i64u.data = '0; i64d.ready = 1'b0;
        repeat (2) tick();
        n_checks++; if (i32d.data !== RV32) begin n_fail++; $display("FAIL reset_data: got %h expected %h", i32d.data, RV32); end
        n_checks++; if (i32d.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", i32d.valid); end
        n_checks++; if (i32u.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", i32u.ready); end
        n_checks++; if (occ32 !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ32); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++; if (i32u.ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", i32u.ready); end
        tick();
        n_checks++; if (i32u.ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b expected 1", i32u.ready); end
    endtask

    task automatic test_streaming;
        i32d.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (i32u.ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, i32u.ready); end
            i32u.valid = 1'b1;
            i32u.data  = 32'(i);
            tick();
            n_checks++; if (i32d.valid !== 1'b1 || i32d.data !== 32'(i)) begin
                n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, i32d.valid, i32d.data, 32'(i)); end
            n_checks++; if (occ32 !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occ32); end
        end
        i32u.valid = 1'b0;
        tick();
        n_checks++; if (i32d.valid !== 1'b0 || i32d.data !== RV32 || occ32 !== 2'd0) begin
            n_fail++; $display("FAIL stream_drain: got v=%b d=%h occ=%0d expected v=0 d=%h occ=0", i32d.valid, i32d.data, occ32, RV32); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hC;
        i32d.ready = 1'b0;
        i32u.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i32u.data = exp_seq[i];
            tick();
            n_checks++; if (i32d.data !== 32'hA || i32d.valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=0000000a", i, i32d.valid, i32d.data); end
            n_checks++; if (occ32 !== ((i == 0) ? 2'd1 : 2'd2)) begin
                n_fail++; $display("FAIL bp_occ[%0d]: got %0d expected %0d", i, occ32, (i == 0) ? 1 : 2); end
            n_checks++; if (i32u.ready !== ((i == 0) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, i32u.ready, (i == 0) ? 1'b1 : 1'b0); end
        end
        // 0xC is still being offered; releasing out_ready should deliver A, B, C with no gaps
        i32d.ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            if (i == 2) i32u.valid = 1'b0;
            n_checks++; if (i32d.valid !== 1'b1 || i32d.data !== exp_seq[i]) begin
                n_fail++; $display("FAIL bp_release[%0d]: got v=%b d=%h expected v=1 d=%h", i, i32d.valid, i32d.data, exp_seq[i]); end
            if (i == 1) i32u.data = 32'hC;
        end
        tick();
        n_checks++; if (i32d.valid !== 1'b0 || occ32 !== 2'd0) begin
            n_fail++; $display("FAIL bp_empty: got v=%b occ=%0d expected v=0 occ=0", i32d.valid, occ32); end
    endtask

    task automatic test_flush;
        i32d.ready = 1'b0;
        i32u.valid = 1'b1;
        i32u.data  = 32'h5; tick();
        i32u.data  = 32'h6; tick();
        n_checks++; if (occ32 !== 2'd2) begin n_fail++; $display("FAIL flush_setup_occ: got %0d expected 2", occ32); end
        i32u.data = 32'h7;
        flush32   = 1'b1;
        tick();
        flush32    = 1'b0;
        i32u.valid = 1'b0;
        n_checks++; if (occ32 !== 2'd0 || i32d.valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got occ=%0d v=%b expected occ=0 v=0", occ32, i32d.valid); end
        n_checks++; if (i32d.data !== RV32) begin n_fail++; $display("FAIL flush_data: got %h expected %h", i32d.data, RV32); end
        n_checks++; if (i32u.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", i32u.ready); end
        tick();
        n_checks++; if (i32d.valid !== 1'b0 || occ32 !== 2'd0) begin
            n_fail++; $display("FAIL flush_dropped: got v=%b occ=%0d expected v=0 occ=0", i32d.valid, occ32); end
    endtask

    task automatic test_async_reset;
        i32d.ready = 1'b0;
        i32u.valid = 1'b1;
        i32u.data  = 32'h42;
        tick();
        i32u.valid = 1'b0;
        n_checks++; if (i32d.valid !== 1'b1 || i32d.data !== 32'h42) begin
            n_fail++; $display("FAIL areset_setup: got v=%b d=%h expected v=1 d=00000042", i32d.valid, i32d.data); end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (i32d.valid !== 1'b0 || i32d.data !== RV32) begin
            n_fail++; $display("FAIL areset_immediate: got v=%b d=%h expected v=0 d=%h", i32d.valid, i32d.data, RV32); end
        n_checks++; if (occ32 !== 2'd0 || i32u.ready !== 1'b0) begin
            n_fail++; $display("FAIL areset_occ_ready: got occ=%0d rdy=%b expected occ=0 rdy=0", occ32, i32u.ready); end
        #2;
        reset_n = 1'b1;
        tick();
        n_checks++; if (i32u.ready !== 1'b1) begin n_fail++; $display("FAIL areset_release_ready: got %b expected 1", i32u.ready); end
    endtask

    // Queue model: held beats in arrival order; head is what out_data must show.
    task automatic test_random;
        logic [7:0]  q8[$];
        logic [63:0] q64[$];
        int beats = 0;
        int cycles = 0;
        logic v, r, f, exp_v, exp_rdy;
        logic [7:0]  exp_d8;
        logic [63:0] exp_d64;
        while (beats < 10000 && cycles < 60000) begin
            exp_v   = (q64.size() != 0);
            exp_rdy = (q64.size() < 2);
            exp_d8  = exp_v ? q8[0]  : RV8;
            exp_d64 = exp_v ? q64[0] : RV64;
            n_checks++; if (i8d.valid !== exp_v || i64d.valid !== exp_v) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b/%b expected %b", cycles, i8d.valid, i64d.valid, exp_v); end
            n_checks++; if (i8d.data !== exp_d8) begin
                n_fail++; $display("FAIL rnd_data8@%0d: got %h expected %h", cycles, i8d.data, exp_d8); end
            n_checks++; if (i64d.data !== exp_d64) begin
                n_fail++; $display("FAIL rnd_data64@%0d: got %h expected %h", cycles, i64d.data, exp_d64); end
            n_checks++; if (i8u.ready !== exp_rdy || i64u.ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready@%0d: got %b/%b expected %b", cycles, i8u.ready, i64u.ready, exp_rdy); end
            n_checks++; if (occ8 !== 2'(q8.size()) || occ64 !== 2'(q64.size())) begin
                n_fail++; $display("FAIL rnd_occ@%0d: got %0d/%0d expected %0d", cycles, occ8, occ64, q64.size()); end
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 63) == 0);
            i8u.valid = v; i64u.valid = v;
            i8d.ready = r; i64d.ready = r;
            i8u.data  = 8'($urandom);
            i64u.data = {$urandom, $urandom};
            flush_r   = f;
            tick();
            cycles++;
            if (exp_v && r) beats++;
            if (f) begin
                q8.delete();
                q64.delete();
            end else begin
                if (exp_v && r) begin
                    void'(q8.pop_front());
                    void'(q64.pop_front());
                end
                if (v && exp_rdy) begin
                    q8.push_back(i8u.data);
                    q64.push_back(i64u.data);
                end
            end
        end
        flush_r = 1'b0; i8u.valid = 1'b0; i64u.valid = 1'b0;
        n_checks++; if (beats < 10000) begin
            n_fail++; $display("FAIL rnd_budget: got %0d beats expected 10000 within 60000 cycles", beats); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
